// File: rtl/cpu_loader_pkg.sv
// Shared types and constants for the UART-to-iRAM program loader.
package cpu_loader_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WRITE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [7:0] CMD_MARK    = 8'hFF;
  localparam logic [7:0] OP_START    = 8'h00;
  localparam logic [7:0] OP_END_RST  = 8'hFF;
  localparam logic [7:0] OP_END_KEEP = 8'hF0;
  localparam logic [7:0] OP_SET_ADDR = 8'h0F;

  localparam int unsigned ERR_W       = 3;
  localparam int unsigned ERR_CSUM    = 0;
  localparam int unsigned ERR_TIMEOUT = 1;
  localparam int unsigned ERR_WRAP    = 2;

endpackage

// File: rtl/loader_word_assembler.sv
// Byte handshake with uart_rx, LSB-first word assembly and partial-word timeout.
module loader_word_assembler
  import cpu_loader_pkg::*;
#(
  parameter int unsigned WORD_BYTES  = 3,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    accept_en,
  input  logic                    packet_ready,
  input  logic [7:0]              uart_packet,
  output logic                    packet_ack,
  output logic                    word_valid,
  output logic                    timeout,
  output logic [8*WORD_BYTES-1:0] word
);

  localparam int unsigned W     = 8 * WORD_BYTES;
  localparam int unsigned CNT_W = $clog2(WORD_BYTES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic             accept;
  logic             last_byte;
  logic [CNT_W-1:0] byte_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  assign accept    = accept_en && packet_ready && !packet_ack;
  assign last_byte = (byte_cnt == CNT_W'(WORD_BYTES - 1));

  // Completion wins over timeout: an accepted byte always clears the timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      packet_ack <= 1'b0;
      word_valid <= 1'b0;
      timeout    <= 1'b0;
      word       <= '0;
      byte_cnt   <= '0;
      tmo_cnt    <= '0;
    end else begin
      word_valid <= 1'b0;
      timeout    <= 1'b0;
      if (accept) begin
        packet_ack <= 1'b1;
      end else if (!packet_ready) begin
        packet_ack <= 1'b0;
      end
      if (accept) begin
        word    <= {uart_packet, word[W-1:8]};
        tmo_cnt <= '0;
        if (last_byte) begin
          byte_cnt   <= '0;
          word_valid <= 1'b1;
        end else begin
          byte_cnt <= CNT_W'(byte_cnt + 1'b1);
        end
      end else if (byte_cnt != '0) begin
        if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
          byte_cnt <= '0;
          tmo_cnt  <= '0;
          timeout  <= 1'b1;
        end else begin
          tmo_cnt <= TMO_W'(tmo_cnt + 1'b1);
        end
      end
    end
  end

endmodule

// File: rtl/cpu_program_loader.sv
// Command FSM: opens/closes load sessions, writes words to iRAM, releases the CPU.
module cpu_program_loader
  import cpu_loader_pkg::*;
#(
  parameter int unsigned WORD_BYTES  = 3,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    HALT_flag,
  input  logic                    packet_ready,
  input  logic [7:0]              uart_packet,
  input  logic                    data_ack,
  input  logic [ADDR_W-1:0]       PC_addr,
  output logic                    packet_ack,
  output logic                    cpu_paused,
  output logic                    reset_PC,
  output logic                    iRAM_write_enable,
  output logic [ADDR_W-1:0]       extern_iRAM_addr,
  output logic [8*WORD_BYTES-1:0] iRAM_data_in,
  output logic                    load_active,
  output logic [ERR_W-1:0]        load_error,
  output logic [ADDR_W-1:0]       words_written
);

  localparam int unsigned W = 8 * WORD_BYTES;

  state_t            state, state_nxt;
  logic              word_valid, timeout;
  logic [W-1:0]      word;
  logic [7:0]        top_byte, op_byte, pl_byte, word_xor;
  logic [7:0]        csum, csum_nxt;
  logic              addr_pend, addr_pend_nxt;
  logic              paused_nxt, reset_pc_nxt, we_nxt, active_nxt;
  logic [ADDR_W-1:0] addr_nxt, ww_nxt;
  logic [W-1:0]      data_nxt;
  logic [ERR_W-1:0]  err_nxt;

  loader_word_assembler #(
    .WORD_BYTES  (WORD_BYTES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_asm (
    .clk          (clk),
    .rst          (rst),
    .accept_en    (state == COLLECT),
    .packet_ready (packet_ready),
    .uart_packet  (uart_packet),
    .packet_ack   (packet_ack),
    .word_valid   (word_valid),
    .timeout      (timeout),
    .word         (word)
  );

  assign top_byte = word[W-1 -: 8];
  assign op_byte  = word[8*(WORD_BYTES-2) +: 8];
  assign pl_byte  = word[7:0];

  always_comb begin
    word_xor = '0;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      word_xor = word_xor ^ word[8*i +: 8];
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    paused_nxt    = cpu_paused;
    reset_pc_nxt  = reset_PC;
    we_nxt        = iRAM_write_enable;
    active_nxt    = load_active;
    addr_nxt      = extern_iRAM_addr;
    ww_nxt        = words_written;
    data_nxt      = iRAM_data_in;
    err_nxt       = load_error;
    csum_nxt      = csum;
    addr_pend_nxt = addr_pend;

    case (state)
      COLLECT: begin
        if (timeout && load_active) err_nxt[ERR_TIMEOUT] = 1'b1;
        if (word_valid) begin
          if (top_byte == CMD_MARK) begin
            // Unknown ops under the command mark are reserved and dropped.
            case (op_byte)
              OP_START: begin
                if (HALT_flag && !load_active) begin
                  paused_nxt    = 1'b1;
                  active_nxt    = 1'b1;
                  ww_nxt        = '0;
                  err_nxt       = '0;
                  csum_nxt      = '0;
                  addr_nxt      = '0;
                  addr_pend_nxt = 1'b0;
                end
              end
              OP_END_RST, OP_END_KEEP: begin
                if (load_active) begin
                  if ((WORD_BYTES >= 3) && (pl_byte != csum)) err_nxt[ERR_CSUM] = 1'b1;
                  reset_pc_nxt = (op_byte == OP_END_RST);
                  state_nxt    = RELEASE;
                end
              end
              OP_SET_ADDR: begin
                if (load_active) addr_pend_nxt = 1'b1;
              end
              default: ;
            endcase
          end else if (load_active) begin
            if (addr_pend) begin
              addr_nxt      = ADDR_W'(word);
              addr_pend_nxt = 1'b0;
            end else begin
              data_nxt  = word;
              csum_nxt  = csum ^ word_xor;
              we_nxt    = 1'b1;
              state_nxt = WRITE;
            end
          end
        end
      end
      WRITE: begin
        if (data_ack) begin
          we_nxt    = 1'b0;
          addr_nxt  = ADDR_W'(extern_iRAM_addr + 1'b1);
          ww_nxt    = ADDR_W'(words_written + 1'b1);
          if (&extern_iRAM_addr) err_nxt[ERR_WRAP] = 1'b1;
          state_nxt = COLLECT;
        end
      end
      RELEASE: begin
        if (!reset_PC || (PC_addr == '0)) begin
          reset_pc_nxt = 1'b0;
          paused_nxt   = 1'b0;
          active_nxt   = 1'b0;
          state_nxt    = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= COLLECT;
      cpu_paused        <= 1'b0;
      reset_PC          <= 1'b0;
      iRAM_write_enable <= 1'b0;
      load_active       <= 1'b0;
      extern_iRAM_addr  <= '0;
      words_written     <= '0;
      iRAM_data_in      <= '0;
      load_error        <= '0;
      csum              <= '0;
      addr_pend         <= 1'b0;
    end else begin
      state             <= state_nxt;
      cpu_paused        <= paused_nxt;
      reset_PC          <= reset_pc_nxt;
      iRAM_write_enable <= we_nxt;
      load_active       <= active_nxt;
      extern_iRAM_addr  <= addr_nxt;
      words_written     <= ww_nxt;
      iRAM_data_in      <= data_nxt;
      load_error        <= err_nxt;
      csum              <= csum_nxt;
      addr_pend         <= addr_pend_nxt;
    end
  end

endmodule
